mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the CPU data bus. It sits beside `ram` behind an address decoder and uses the same a/wd/write_byte_enable/we/rd signalling that the CPU drives as initiator.
- CPU stores to TXDATA are queued in a FIFO and serialized onto an 8N1 UART line.
- STATUS, divisor and cycle-counter registers are readable over the same bus, so programs can poll the block and measure time.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DIV_RESET, 16'd868, reset value of the DIV register, in clock cycles per bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sel  input  1  decoder select; this block's address window is active.
- a  input  32  byte address; only a[3:2] is decoded.
- wd  input  32  write data.
- write_byte_enable  input  4  per-byte write enables.
- we  input  1  write strobe; writes are qualified by sel.
- rd  output  32  read data; combinational from a[3:2], 0 when sel=0.
- tx  output  1  UART serial line; idles high.
- irq_empty  output  1  registered; high while the FIFO is empty and the shifter is idle.

Behaviour:
- Register map, selected by a[3:2]:
  - 0 TXDATA: write-only; reads return 0.
  - 1 STATUS: read {24'b0, count[3:0], overflow, busy, full, empty}.
  - 2 DIV: R/W, 16 bits in rd[15:0].
  - 3 CYCLES: read-only, 32-bit free-running counter.
- Write acceptance: a write takes effect only on a clock edge with sel & we. Bytes with write_byte_enable[i]=0 are not modified.
- TXDATA write with be[0]=1 enqueues wd[7:0].
  - Accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write with be[0]=1 and wd[3]=1 clears overflow (W1C); all other STATUS bits ignore writes.
- DIV write updates the enabled bytes.
  - Effective bit period is max(DIV,1) cycles.
  - A new value takes effect at the next bit boundary, never mid-bit.
- CYCLES increments by 1 every cycle and wraps at 2^32; writes are ignored.
- rd is combinational, with no wait states. A read of STATUS in the same cycle as a write shows the pre-edge value.
- Transmitter FSM:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for one bit period, shift right, bit index +1. After index 7 completes, go to STOP.
  - STOP: tx=1 for one bit period, then go to IDLE. Back-to-back bytes therefore have one IDLE cycle between the stop bit and the next start bit.
- Bit timer counts 0..period-1; the last count ends the bit.
- busy = (state != IDLE).
- irq_empty is registered: it reflects empty & ~busy from the previous cycle.
- Boundaries:
  - Simultaneous push and pop when full: count stays at FIFO_DEPTH and no overflow.
  - Push when empty and idle: the first start bit begins 2 cycles after the write edge (edge+1 pop/IDLE→START, edge+2 tx=0).
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A write with sel=0 has no effect.
- Reset, including mid-frame:
  - Next edge: tx=1, state IDLE, FIFO emptied, count=0, overflow=0, DIV=DIV_RESET, CYCLES=0, irq_empty=1.
  - rd remains combinational.

Decomposition:
- cpu_types gains the following, shared with the address decoder and the benches:
  - enum mmio_uart_reg_t {UART_TXDATA=0, UART_STATUS=1, UART_DIV=2, UART_CYCLES=3}
  - enum uart_tx_state_t {IDLE, START, DATA, STOP}
  - localparam UART_STATUS_OVERFLOW_BIT=3
- One sub-module, sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH).
  - Ports: clk, rst, push, din, pop, dout, count, full, empty.
  - Read is first-word-fall-through.
  - It is reusable later for an RX path.

Test Plan:
- Reset → tx=1, rd(STATUS)=0x01, rd(DIV)=868, irq_empty=1, rd(CYCLES)=0 right after rst falls.
- DIV=4, store 0xA5 to TXDATA → tx is low for 4 cycles starting 2 cycles after the write. Then data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. busy=1 for the whole frame and irq_empty returns to 1 afterwards.
- DIV=1, 9 back-to-back TXDATA stores with the line busy → STATUS shows full=1, count=8 and overflow=1 after the 9th store. Writing STATUS with wd=0x08 clears overflow. The bench decodes 8 correct bytes in order.
- TXDATA store with be=4'b0010 → nothing is enqueued, count stays 0. DIV store with be=4'b0001, wd=0x0003, from DIV_RESET=0x0364 → DIV reads 0x0303.
- Change DIV from 4 to 8 mid-DATA bit → the current bit still lasts 4 cycles and the following bits last 8.
- Assert rst mid-DATA with 3 bytes queued → next cycle tx=1, count=0, busy=0. After release, no further UART activity appears.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types for the memory-mapped UART transmitter: register map, FSM
// state encoding, STATUS bit positions and the bit-period helper.
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    UART_TXDATA = 2'd0,
    UART_STATUS = 2'd1,
    UART_DIV    = 2'd2,
    UART_CYCLES = 2'd3
  } mmio_uart_reg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_STATUS_OVERFLOW_BIT = 3;
  localparam int UART_STATUS_BUSY_BIT     = 2;
  localparam int UART_STATUS_FULL_BIT     = 1;
  localparam int UART_STATUS_EMPTY_BIT    = 0;

  // A divisor of zero would stall the bit timer, so it is treated as one.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus slice seen by an MMIO responder behind the address decoder.
// Handshake: no valid/ready; a write lands on any rising edge with sel & we,
// and rd is combinational from a[3:2] with no wait states.
interface mmio_uart_tx_if;
  logic        sel;
  logic [31:0] a;
  logic [31:0] wd;
  logic [3:0]  write_byte_enable;
  logic        we;
  logic [31:0] rd;

  modport master (output sel, a, wd, write_byte_enable, we, input rd);
  modport slave  (input sel, a, wd, write_byte_enable, we, output rd);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores queue into a FIFO and are
// shifted out LSB first; STATUS, DIV and a free-running CYCLES counter are readable.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 irq_empty,
  output logic [1:0]           o_dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  mmio_uart_reg_t w_reg;
  logic           w_wr;
  logic           w_txdata_wr;
  logic           w_push;
  logic           w_pop;
  logic           w_busy;
  logic           w_bit_end;
  logic [7:0]     w_fifo_dout;
  logic [CW-1:0]  w_fifo_count;
  logic [6:0]     w_count_ext;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [7:0]     w_status;
  logic           w_unused;

  logic [15:0]    r_div;
  logic [31:0]    r_cycles;
  logic           r_overflow;
  logic           r_irq_empty;
  logic [1:0]     r_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_idx;
  logic [15:0]    r_bit_cnt;
  logic [15:0]    r_period;
  logic           r_tx;

  assign w_reg       = mmio_uart_reg_t'(bus.a[3:2]);
  assign w_wr        = bus.sel & bus.we;
  assign w_txdata_wr = w_wr & (w_reg == UART_TXDATA) & bus.write_byte_enable[0];
  assign w_busy      = (r_state != ST_IDLE);
  assign w_pop       = ~w_busy & ~w_fifo_empty;
  assign w_push      = w_txdata_wr & (~w_fifo_full | w_pop);
  assign w_bit_end   = (r_bit_cnt == r_period - 16'd1);
  assign w_count_ext = 7'(w_fifo_count);
  assign w_status    = {w_count_ext[3:0], r_overflow, w_busy, w_fifo_full, w_fifo_empty};
  assign w_unused    = ^{bus.a[31:4], bus.a[1:0], bus.wd[31:16],
                         bus.write_byte_enable[3:2], w_count_ext[6:4]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (bus.wd[7:0]),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (w_reg)
        UART_TXDATA: bus.rd = '0;
        UART_STATUS: bus.rd = {24'b0, w_status};
        UART_DIV:    bus.rd = {16'b0, r_div};
        UART_CYCLES: bus.rd = r_cycles;
        default:     bus.rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= DIV_RESET;
      r_cycles    <= '0;
      r_overflow  <= 1'b0;
      r_irq_empty <= 1'b1;
    end else begin
      r_cycles    <= r_cycles + 32'd1;
      r_irq_empty <= w_fifo_empty & ~w_busy;
      if (w_wr && w_reg == UART_DIV) begin
        if (bus.write_byte_enable[0]) r_div[7:0]  <= bus.wd[7:0];
        if (bus.write_byte_enable[1]) r_div[15:8] <= bus.wd[15:8];
      end
      if (w_txdata_wr && !w_push)
        r_overflow <= 1'b1;
      else if (w_wr && w_reg == UART_STATUS && bus.write_byte_enable[0]
               && bus.wd[UART_STATUS_OVERFLOW_BIT])
        r_overflow <= 1'b0;
    end
  end

  // r_period is reloaded only at a bit boundary, so DIV writes never stretch
  // or shorten the bit in flight. tx is registered and trails r_state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_bit_cnt <= '0;
      r_period  <= 16'd1;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_START: r_tx <= 1'b0;
        ST_DATA:  r_tx <= r_shift[0];
        default:  r_tx <= 1'b1;
      endcase

      if (r_state == ST_IDLE) begin
        if (w_pop) begin
          r_shift   <= w_fifo_dout;
          r_state   <= ST_START;
          r_bit_cnt <= '0;
          r_period  <= bit_period(r_div);
        end
      end else if (w_bit_end) begin
        r_bit_cnt <= '0;
        r_period  <= bit_period(r_div);
        if (r_state == ST_START) begin
          r_state   <= ST_DATA;
          r_bit_idx <= '0;
        end else if (r_state == ST_DATA) begin
          r_shift   <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) r_state <= ST_STOP;
        end else begin
          r_state <= ST_IDLE;
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + 16'd1;
      end
    end
  end

  assign tx          = r_tx;
  assign irq_empty   = r_irq_empty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus driver tasks, a UART line monitor that
// pops a scoreboard queue, cycle-exact waveform checks and a final report.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  logic       clk;
  logic       rst;
  logic       tx;
  logic       irq_empty;
  logic [1:0] dbg_state;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .tx          (tx),
    .irq_empty   (irq_empty),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_en   = 1'b0;
  int         mon_div  = 4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] reg_addr(input logic [1:0] r);
    return {28'h0, r, 2'b00};
  endfunction

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus_if.sel = 1'b1;
    bus_if.we  = 1'b1;
    bus_if.a   = reg_addr(r);
    bus_if.wd  = d;
    bus_if.write_byte_enable = be;
    @(negedge clk);
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;
    bus_if.write_byte_enable = 4'b0000;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    bus_if.sel = 1'b1;
    bus_if.we  = 1'b0;
    bus_if.a   = reg_addr(r);
    #1;
    d = bus_if.rd;
    bus_if.sel = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (irq_empty === 1'b1) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  // Expected 8N1 line level at sample offset off from the start bit, d cycles per bit.
  function automatic logic frame_bit(input int off, input logic [7:0] b, input int d);
    if (off < 0)     return 1'b1;
    if (off < d)     return 1'b0;
    if (off < 9 * d) return b[(off / d) - 1];
    return 1'b1;
  endfunction

  // ---------------- UART line monitor ----------------
  initial begin : monitor
    int         d;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        d = mon_div;
        repeat (d / 2) @(negedge clk);
        check("mon_start_bit", tx, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (d) @(negedge clk);
          got[k] = tx;
        end
        repeat (d) @(negedge clk);
        check("mon_stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          check("mon_unexpected_byte", got, 8'hxx);
        end else begin
          check("mon_byte", got, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0]  rdata;
  logic [127:0] act_tx, exp_tx, act_busy, exp_busy, act_irq, exp_irq;
  logic [7:0]   burst_data [10];
  int           lows;

  initial begin
    rst = 1'b1;
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;
    bus_if.a   = '0;
    bus_if.wd  = '0;
    bus_if.write_byte_enable = 4'b0000;

    // Reset values, read in the half cycle right after rst falls.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_if.sel = 1'b1;
    bus_if.a = reg_addr(UART_CYCLES); #1; check("rst_cycles", bus_if.rd, 32'd0);
    bus_if.a = reg_addr(UART_STATUS); #1; check("rst_status", bus_if.rd, 32'h01);
    bus_if.a = reg_addr(UART_DIV);    #1; check("rst_div", bus_if.rd, 32'd868);
    bus_if.a = reg_addr(UART_TXDATA); #1; check("rst_txdata_read", bus_if.rd, 32'd0);
    check("rst_tx", tx, 1'b1);
    check("rst_irq_empty", irq_empty, 1'b1);
    bus_if.sel = 1'b0;
    repeat (5) @(negedge clk);
    bus_if.sel = 1'b1;
    bus_if.a = reg_addr(UART_CYCLES); #1; check("cycles_after_5", bus_if.rd, 32'd5);
    bus_if.sel = 1'b0;

    // DIV=4, single byte 0xA5: exact frame timing, busy and irq_empty.
    bus_write(UART_DIV, 32'd4, 4'b0011);
    mon_div = 4;
    mon_en  = 1'b1;
    exp_q.push_back(8'hA5);
    bus_write(UART_TXDATA, 32'h0000_00A5, 4'b0001);
    act_tx = '0; exp_tx = '0; act_busy = '0; exp_busy = '0; act_irq = '0; exp_irq = '0;
    bus_if.sel = 1'b1;
    bus_if.a   = reg_addr(UART_STATUS);
    for (int i = 0; i < 43; i++) begin
      #1;
      act_tx[i]   = tx;
      act_busy[i] = bus_if.rd[UART_STATUS_BUSY_BIT];
      act_irq[i]  = irq_empty;
      exp_tx[i]   = frame_bit(i - 2, 8'hA5, 4);
      exp_busy[i] = (i >= 1 && i <= 40);
      exp_irq[i]  = !(i >= 1 && i <= 41);
      @(negedge clk);
    end
    bus_if.sel = 1'b0;
    check("a5_tx_waveform", act_tx, exp_tx);
    check("a5_busy_waveform", act_busy, exp_busy);
    check("a5_irq_waveform", act_irq, exp_irq);

    // DIV=1: one byte starts, then 9 stores back-to-back; the 9th overflows.
    bus_write(UART_DIV, 32'd1, 4'b0011);
    mon_div = 1;
    burst_data[0] = 8'h3C; burst_data[1] = 8'h01; burst_data[2] = 8'h80;
    burst_data[3] = 8'hFF; burst_data[4] = 8'h00; burst_data[5] = 8'h5A;
    burst_data[6] = 8'hC3; burst_data[7] = 8'h7E; burst_data[8] = 8'h81;
    burst_data[9] = 8'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_if.sel = 1'b1;
      bus_if.we  = 1'b1;
      bus_if.a   = reg_addr(UART_TXDATA);
      bus_if.wd  = {24'h0, burst_data[i]};
      bus_if.write_byte_enable = 4'b0001;
      if (i < 9) exp_q.push_back(burst_data[i]);
    end
    @(negedge clk);
    bus_if.we = 1'b0;
    bus_if.write_byte_enable = 4'b0000;
    bus_if.a  = reg_addr(UART_STATUS);
    #1;
    check("status_full_overflow", bus_if.rd, 32'h8E);
    bus_if.sel = 1'b0;
    bus_write(UART_STATUS, 32'h08, 4'b0001);
    bus_read(UART_STATUS, rdata);
    check("overflow_w1c", rdata[UART_STATUS_OVERFLOW_BIT], 1'b0);
    wait_idle("burst_drain_timeout", 1000);
    repeat (4) @(negedge clk);
    check("burst_all_bytes_seen", exp_q.size(), 0);
    mon_en = 1'b0;

    // Byte enables and sel qualification, starting from a fresh reset.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    bus_write(UART_TXDATA, 32'h0000_AB00, 4'b0010);
    bus_read(UART_STATUS, rdata);
    check("txdata_be1_no_push", rdata, 32'h01);
    bus_write(UART_DIV, 32'h0000_0003, 4'b0001);
    bus_read(UART_DIV, rdata);
    check("div_byte0_write", rdata, 32'h0303);
    @(negedge clk);
    bus_if.sel = 1'b0; bus_if.we = 1'b1; bus_if.a = reg_addr(UART_DIV);
    bus_if.wd = 32'h0000_0005; bus_if.write_byte_enable = 4'b1111;
    @(negedge clk);
    bus_if.a = reg_addr(UART_TXDATA);
    @(negedge clk);
    bus_if.we = 1'b0; bus_if.write_byte_enable = 4'b0000;
    bus_read(UART_DIV, rdata);
    check("div_sel0_ignored", rdata, 32'h0303);
    bus_read(UART_STATUS, rdata);
    check("txdata_sel0_ignored", rdata, 32'h01);

    // DIV 4 -> 8 in the middle of data bit 0 of byte 0x55.
    bus_write(UART_DIV, 32'd4, 4'b0011);
    bus_write(UART_TXDATA, 32'h55, 4'b0001);
    act_tx = '0; exp_tx = '0;
    for (int i = 0; i < 76; i++) begin
      #1;
      act_tx[i] = tx;
      if (i < 2)       exp_tx[i] = 1'b1;
      else if (i < 6)  exp_tx[i] = 1'b0;
      else if (i < 10) exp_tx[i] = 1'b1;
      else if (i < 66) exp_tx[i] = frame_bit(((i - 10) / 8) + 2, 8'h55, 1);
      else             exp_tx[i] = 1'b1;
      if (i == 6) begin
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.a = reg_addr(UART_DIV);
        bus_if.wd = 32'd8; bus_if.write_byte_enable = 4'b0011;
      end
      if (i == 7) begin
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.write_byte_enable = 4'b0000;
      end
      @(negedge clk);
    end
    check("div_change_tx_waveform", act_tx, exp_tx);
    wait_idle("div_change_idle_timeout", 200);

    // Reset in the middle of a frame with three bytes still queued.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.a = reg_addr(UART_TXDATA);
      bus_if.wd = 32'hF0 + i; bus_if.write_byte_enable = 4'b0001;
    end
    @(negedge clk);
    bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.write_byte_enable = 4'b0000;
    repeat (20) @(negedge clk);
    bus_read(UART_STATUS, rdata);
    check("pre_reset_status", rdata, 32'h34);
    check("pre_reset_in_data", dbg_state, DATA);
    rst = 1'b1;
    @(negedge clk);
    bus_if.sel = 1'b1;
    bus_if.a   = reg_addr(UART_STATUS);
    #1;
    check("midframe_rst_status", bus_if.rd, 32'h01);
    check("midframe_rst_tx", tx, 1'b1);
    check("midframe_rst_irq", irq_empty, 1'b1);
    check("midframe_rst_state", dbg_state, IDLE);
    bus_if.a = reg_addr(UART_DIV);
    #1;
    check("midframe_rst_div", bus_if.rd, 32'd868);
    bus_if.sel = 1'b0;
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || dbg_state !== IDLE) lows++;
    end
    check("no_activity_after_reset", lows, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
